// File: rtl/hsync_gen.sv
`default_nettype none
// ============================================================================
// Module   : hsync_gen
// Brief    : Horizontal VGA timing generator. Divides the clock down to a
//            pixel-rate strobe, counts pixels across a line and produces
//            horizontal blank, hsync and an end-of-line strobe.
// Revision : 1.0 - initial release
// ============================================================================
module hsync_gen #(
  parameter int PIXELS          = 640,
  parameter int FRONT_PORCH     = 16,
  parameter int HSYNC_WIDTH     = 96,
  parameter int BACK_PORCH      = 48,
  parameter int CLK_DIV         = 4,
  parameter int SYNC_ACTIVE_LOW = 1,
  localparam int H_TOTAL        = PIXELS + FRONT_PORCH + HSYNC_WIDTH + BACK_PORCH,
  localparam int H_COUNT_W      = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1
) (
  input  logic                 clk_in,
  input  logic                 reset,
  input  logic                 enable,
  output logic                 pix_en,
  output logic [H_COUNT_W-1:0] h_count,
  output logic                 h_blank,
  output logic                 hsync,
  output logic                 line_end
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0]     c_DIV_LAST    = DIV_W'(CLK_DIV - 1);
  localparam logic [H_COUNT_W-1:0] c_H_LAST      = H_COUNT_W'(H_TOTAL - 1);
  localparam logic [H_COUNT_W-1:0] c_ACTIVE_LAST = H_COUNT_W'(PIXELS - 1);
  localparam logic [H_COUNT_W-1:0] c_FRONT_LAST  = H_COUNT_W'(PIXELS + FRONT_PORCH - 1);
  localparam logic [H_COUNT_W-1:0] c_SYNC_LAST   = H_COUNT_W'(PIXELS + FRONT_PORCH + HSYNC_WIDTH - 1);
  localparam logic                 c_SYNC_ON     = (SYNC_ACTIVE_LOW != 0) ? 1'b0 : 1'b1;

  // Reject degenerate timing parameters at elaboration.
  if ((PIXELS < 1) || (FRONT_PORCH < 1) || (HSYNC_WIDTH < 1) ||
      (BACK_PORCH < 1) || (CLK_DIV < 1) ||
      ((SYNC_ACTIVE_LOW != 0) && (SYNC_ACTIVE_LOW != 1))) begin : g_param_check
    $error("hsync_gen: timing parameters must be >= 1 and SYNC_ACTIVE_LOW must be 0 or 1");
  end

  typedef enum logic [1:0] {
    ST_ACTIVE = 2'd0,
    ST_FRONT  = 2'd1,
    ST_SYNC   = 2'd2,
    ST_BACK   = 2'd3
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [DIV_W-1:0]       r_div;
  logic [DIV_W-1:0]       w_div_nxt;
  logic [H_COUNT_W-1:0]   r_h;
  logic [H_COUNT_W-1:0]   w_h_nxt;
  logic                   w_adv;
  logic                   w_pix_nxt;
  logic                   r_pix_en;
  logic                   r_line_end;
  logic                   r_h_blank;
  logic                   r_hsync;

  // Next-state logic: prescaler, pixel counter and region transitions.
  // A pixel advance happens on an enabled edge that closes a divider period;
  // outputs are derived from these next values so they move with h_count.
  always_comb begin
    w_adv       = enable && (r_div == c_DIV_LAST);
    w_div_nxt   = r_div;
    w_h_nxt     = r_h;
    w_state_nxt = r_state;

    if (enable) begin
      w_div_nxt = w_adv ? '0 : r_div + DIV_W'(1);
    end

    if (w_adv) begin
      w_h_nxt = (r_h == c_H_LAST) ? '0 : r_h + H_COUNT_W'(1);
      case (r_state)
        ST_ACTIVE: if (r_h == c_ACTIVE_LAST) w_state_nxt = ST_FRONT;
        ST_FRONT:  if (r_h == c_FRONT_LAST)  w_state_nxt = ST_SYNC;
        ST_SYNC:   if (r_h == c_SYNC_LAST)   w_state_nxt = ST_BACK;
        ST_BACK:   if (r_h == c_H_LAST)      w_state_nxt = ST_ACTIVE;
        default:                             w_state_nxt = ST_ACTIVE;
      endcase
    end

    // The strobe marks the last clock of a pixel period; it only fires on
    // cycles entered through an enabled edge.
    w_pix_nxt = enable && (w_div_nxt == c_DIV_LAST);
  end

  // State and registered outputs; reset takes priority over enable.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_div      <= '0;
      r_h        <= '0;
      r_state    <= ST_ACTIVE;
      r_pix_en   <= 1'b0;
      r_line_end <= 1'b0;
      r_h_blank  <= 1'b0;
      r_hsync    <= ~c_SYNC_ON;
    end else begin
      r_div      <= w_div_nxt;
      r_h        <= w_h_nxt;
      r_state    <= w_state_nxt;
      r_pix_en   <= w_pix_nxt;
      r_line_end <= w_pix_nxt && (w_h_nxt == c_H_LAST);
      r_h_blank  <= (w_state_nxt != ST_ACTIVE);
      r_hsync    <= (w_state_nxt == ST_SYNC) ? c_SYNC_ON : ~c_SYNC_ON;
    end
  end

  assign pix_en   = r_pix_en;
  assign h_count  = r_h;
  assign h_blank  = r_h_blank;
  assign hsync    = r_hsync;
  assign line_end = r_line_end;

endmodule
`default_nettype wire
